// File: rtl/branch_repair_ctrl_pkg.sv
// rtl/branch_repair_ctrl_pkg.sv - shared constants, types and helpers for the branch repair controller
package branch_repair_ctrl_pkg;

  localparam int CKPT_W_DEF     = 16;
  localparam int RA_W_DEF       = 4;
  localparam int UPD_FIFO_DEPTH = 2;

  localparam int RA_NEED_REPAIR = 0;
  localparam int RA_RESTORE_RAS = 1;
  localparam int RA_UPDATE_BTB  = 2;
  localparam int RA_UPDATE_PHT  = 3;

  localparam logic [31:0] DELAY_SLOT_OFF = 32'd8;

  typedef enum logic [0:0] {
    DRN_IDLE = 1'b0,
    DRN_REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        btb;
    logic        pht;
  } upd_entry_t;

  localparam int UPD_ENTRY_W = $bits(upd_entry_t);

  // Not-taken resumes after the delay slot; the add wraps modulo 2^32.
  function automatic logic [31:0] repair_next_pc(input logic [31:0] err_pc,
                                                 input logic [31:0] dest,
                                                 input logic        take);
    return take ? dest : err_pc + DELAY_SLOT_OFF;
  endfunction

endpackage

// File: rtl/repair_upd_fifo.sv
// rtl/repair_upd_fifo.sv - small circular FIFO for predictor training writes
module repair_upd_fifo
  import branch_repair_ctrl_pkg::*;
#(
  parameter int W     = UPD_ENTRY_W,
  parameter int DEPTH = UPD_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/branch_repair_ctrl.sv
// rtl/branch_repair_ctrl.sv - mispredict/exception redirect, checkpoint restore and predictor training queue
module branch_repair_ctrl
  import branch_repair_ctrl_pkg::*;
#(
  parameter int CKPT_W = CKPT_W_DEF,
  parameter int RA_W   = RA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sba_flush_i,
  input  logic [31:0]       sba_erroVAddr_i,
  input  logic [31:0]       sba_corrDest_i,
  input  logic              sba_corrTake_i,
  input  logic [CKPT_W-1:0] sba_checkPoint_i,
  input  logic [RA_W-1:0]   sba_repairAction_i,
  input  logic              cp0_excOccur_i,
  input  logic [31:0]       cp0_excDest_i,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_pc_o,
  output logic              restore_valid_o,
  output logic [CKPT_W-1:0] restore_ckpt_o,
  output logic              restore_ras_o,
  output logic              upd_valid_o,
  input  logic              upd_ready_i,
  output logic [31:0]       upd_pc_o,
  output logic [31:0]       upd_target_o,
  output logic              upd_taken_o,
  output logic              upd_btb_o,
  output logic              upd_pht_o,
  output logic              busy_o,
  output logic [7:0]        drop_cnt_o
);

  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              restore_valid_q, restore_valid_d;
  logic [CKPT_W-1:0] restore_ckpt_q, restore_ckpt_d;
  logic              restore_ras_q, restore_ras_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  drain_state_e      state_q, state_d;

  logic       sba_evt, sba_acc, push_req, pop;
  logic       fifo_full, fifo_empty;
  upd_entry_t push_entry, head_entry;

  assign sba_evt  = sba_flush_i && sba_repairAction_i[RA_NEED_REPAIR];
  assign sba_acc  = sba_evt && !cp0_excOccur_i;
  assign push_req = sba_acc && (sba_repairAction_i[RA_UPDATE_BTB] || sba_repairAction_i[RA_UPDATE_PHT]);
  assign pop      = (state_q == DRN_REQ) && upd_ready_i;

  always_comb begin
    push_entry.pc     = sba_erroVAddr_i;
    push_entry.target = sba_corrDest_i;
    push_entry.taken  = sba_corrTake_i;
    push_entry.btb    = sba_repairAction_i[RA_UPDATE_BTB];
    push_entry.pht    = sba_repairAction_i[RA_UPDATE_PHT];
  end

  repair_upd_fifo #(
    .W     (UPD_ENTRY_W),
    .DEPTH (UPD_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Exceptions win the redirect and swallow any same-cycle mispredict report.
  always_comb begin
    redirect_valid_d = cp0_excOccur_i || sba_evt;
    redirect_pc_d    = '0;
    restore_valid_d  = sba_acc;
    restore_ckpt_d   = '0;
    restore_ras_d    = 1'b0;
    drop_cnt_d       = drop_cnt_q;
    if (cp0_excOccur_i) begin
      redirect_pc_d = cp0_excDest_i;
    end else if (sba_evt) begin
      redirect_pc_d  = repair_next_pc(sba_erroVAddr_i, sba_corrDest_i, sba_corrTake_i);
      restore_ckpt_d = sba_checkPoint_i;
      restore_ras_d  = sba_repairAction_i[RA_RESTORE_RAS];
    end
    if (push_req && fifo_full && !pop && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    upd_valid_o = 1'b0;
    case (state_q)
      DRN_IDLE: begin
        if (!fifo_empty) state_d = DRN_REQ;
      end
      DRN_REQ: begin
        upd_valid_o = 1'b1;
        // Leaving REQ only when the popped head was the last entry and nothing arrives.
        if (upd_ready_i && !fifo_full && !push_req) state_d = DRN_IDLE;
      end
      default: state_d = DRN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      restore_valid_q  <= 1'b0;
      restore_ckpt_q   <= '0;
      restore_ras_q    <= 1'b0;
      drop_cnt_q       <= '0;
      state_q          <= DRN_IDLE;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      restore_valid_q  <= restore_valid_d;
      restore_ckpt_q   <= restore_ckpt_d;
      restore_ras_q    <= restore_ras_d;
      drop_cnt_q       <= drop_cnt_d;
      state_q          <= state_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign restore_valid_o  = restore_valid_q;
  assign restore_ckpt_o   = restore_ckpt_q;
  assign restore_ras_o    = restore_ras_q;
  assign drop_cnt_o       = drop_cnt_q;
  assign busy_o           = !fifo_empty;
  assign upd_pc_o         = head_entry.pc;
  assign upd_target_o     = head_entry.target;
  assign upd_taken_o      = head_entry.taken;
  assign upd_btb_o        = head_entry.btb;
  assign upd_pht_o        = head_entry.pht;

endmodule

// File: tb/tb_branch_repair_ctrl.sv
// tb/tb_branch_repair_ctrl.sv - self-checking bench for branch_repair_ctrl
module tb_branch_repair_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sba_flush_i;
  logic [31:0] sba_erroVAddr_i, sba_corrDest_i;
  logic        sba_corrTake_i;
  logic [15:0] sba_checkPoint_i;
  logic [3:0]  sba_repairAction_i;
  logic        cp0_excOccur_i;
  logic [31:0] cp0_excDest_i;
  logic        redirect_valid_o, restore_valid_o, restore_ras_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] restore_ckpt_o;
  logic        upd_valid_o, upd_ready_i, upd_taken_o, upd_btb_o, upd_pht_o, busy_o;
  logic [31:0] upd_pc_o, upd_target_o;
  logic [7:0]  drop_cnt_o;

  always #5 clk = ~clk;

  branch_repair_ctrl dut (
    .clk(clk), .rst(rst),
    .sba_flush_i(sba_flush_i), .sba_erroVAddr_i(sba_erroVAddr_i),
    .sba_corrDest_i(sba_corrDest_i), .sba_corrTake_i(sba_corrTake_i),
    .sba_checkPoint_i(sba_checkPoint_i), .sba_repairAction_i(sba_repairAction_i),
    .cp0_excOccur_i(cp0_excOccur_i), .cp0_excDest_i(cp0_excDest_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .restore_valid_o(restore_valid_o), .restore_ckpt_o(restore_ckpt_o),
    .restore_ras_o(restore_ras_o), .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
    .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o), .upd_taken_o(upd_taken_o),
    .upd_btb_o(upd_btb_o), .upd_pht_o(upd_pht_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: training queue of at most two entries, pulses computed from the rules.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk, btb, pht;
  } ent_t;

  ent_t        q[$];
  logic        m_rv, m_sv, m_ras, m_uv;
  logic [31:0] m_rpc;
  logic [15:0] m_ck;
  int          m_drop;
  logic        ne_before, evt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_rv = 0; m_sv = 0; m_ras = 0; m_uv = 0; m_rpc = 0; m_ck = 0; m_drop = 0;
    end else begin
      ne_before = (q.size() > 0);
      if (m_uv && upd_ready_i) void'(q.pop_front());
      evt   = sba_flush_i && sba_repairAction_i[0];
      m_rv  = cp0_excOccur_i || evt;
      m_rpc = cp0_excOccur_i ? cp0_excDest_i
            : (sba_corrTake_i ? sba_corrDest_i : sba_erroVAddr_i + 32'd8);
      m_sv  = evt && !cp0_excOccur_i;
      m_ck  = sba_checkPoint_i;
      m_ras = sba_repairAction_i[1];
      if (m_sv && (sba_repairAction_i[2] || sba_repairAction_i[3])) begin
        if (q.size() < 2)
          q.push_back('{sba_erroVAddr_i, sba_corrDest_i, sba_corrTake_i,
                        sba_repairAction_i[2], sba_repairAction_i[3]});
        else if (m_drop < 255)
          m_drop++;
      end
      // A write is offered once the queue has been non-empty for a full cycle.
      m_uv = (q.size() > 0) && ne_before;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("cmp_redirect_valid", redirect_valid_o, m_rv);
      if (m_rv) chk("cmp_redirect_pc", redirect_pc_o, m_rpc);
      chk("cmp_restore_valid", restore_valid_o, m_sv);
      if (m_sv) begin
        chk("cmp_restore_ckpt", restore_ckpt_o, m_ck);
        chk("cmp_restore_ras", restore_ras_o, m_ras);
      end
      chk("cmp_upd_valid", upd_valid_o, m_uv);
      if (m_uv && q.size() > 0) begin
        chk("cmp_upd_pc", upd_pc_o, q[0].pc);
        chk("cmp_upd_target", upd_target_o, q[0].tgt);
        chk("cmp_upd_flags", {upd_taken_o, upd_btb_o, upd_pht_o}, {q[0].tk, q[0].btb, q[0].pht});
      end
      chk("cmp_busy", busy_o, q.size() > 0);
      chk("cmp_drop_cnt", drop_cnt_o, m_drop);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] va, input logic [31:0] dest, input logic take,
                    input logic [15:0] ck, input logic [3:0] ra,
                    input logic exc, input logic [31:0] exc_dest);
    sba_flush_i = 1; sba_erroVAddr_i = va; sba_corrDest_i = dest; sba_corrTake_i = take;
    sba_checkPoint_i = ck; sba_repairAction_i = ra;
    cp0_excOccur_i = exc; cp0_excDest_i = exc_dest;
    step();
    sba_flush_i = 0; cp0_excOccur_i = 0;
  endtask

  initial begin
    rst = 1;
    sba_flush_i = 0; sba_erroVAddr_i = 0; sba_corrDest_i = 0; sba_corrTake_i = 0;
    sba_checkPoint_i = 0; sba_repairAction_i = 0; cp0_excOccur_i = 0; cp0_excDest_i = 0;
    upd_ready_i = 1;
    repeat (2) step();
    chk("rst_redirect_valid", redirect_valid_o, 0);
    chk("rst_upd_valid", upd_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    rst = 0;
    step();

    // Taken mispredict with training.
    ev(32'h1000, 32'h2000, 1, 16'hA5A5, 4'b1101, 0, 0);
    chk("s1_redirect_valid", redirect_valid_o, 1);
    chk("s1_redirect_pc", redirect_pc_o, 32'h2000);
    chk("s1_restore_valid", restore_valid_o, 1);
    chk("s1_restore_ras", restore_ras_o, 0);
    chk("s1_restore_ckpt", restore_ckpt_o, 16'hA5A5);
    chk("s1_upd_valid_n1", upd_valid_o, 0);
    step();
    chk("s1_upd_valid_n2", upd_valid_o, 1);
    chk("s1_upd_pc", upd_pc_o, 32'h1000);
    chk("s1_upd_target", upd_target_o, 32'h2000);
    chk("s1_redirect_drop", redirect_valid_o, 0);
    step();
    chk("s1_upd_done", upd_valid_o, 0);
    chk("s1_busy_done", busy_o, 0);

    // NEED_REPAIR clear: ignored.
    ev(32'h4000, 32'h5000, 1, 16'h1111, 4'b1110, 0, 0);
    chk("nr_redirect_valid", redirect_valid_o, 0);
    chk("nr_busy", busy_o, 0);

    // Not-taken wrap-around, RAS restore, no enqueue.
    ev(32'hFFFF_FFFC, 32'h1234_5678, 0, 16'h1234, 4'b0011, 0, 0);
    chk("s2_redirect_pc", redirect_pc_o, 32'h0000_0004);
    chk("s2_restore_ras", restore_ras_o, 1);
    chk("s2_busy", busy_o, 0);
    step();

    // Exception beats a simultaneous mispredict; queued entry survives.
    upd_ready_i = 0;
    ev(32'h100, 32'h200, 1, 16'h0001, 4'b0101, 0, 0);
    ev(32'h300, 32'h400, 1, 16'h0002, 4'b1101, 1, 32'hBFC0_0380);
    chk("s3_redirect_pc", redirect_pc_o, 32'hBFC0_0380);
    chk("s3_restore_valid", restore_valid_o, 0);
    chk("s3_model_qsize", q.size(), 1);
    chk("s3_busy", busy_o, 1);

    // Full queue drops the third training event.
    ev(32'h500, 32'h600, 0, 16'h0003, 4'b1001, 0, 0);
    ev(32'h700, 32'h800, 1, 16'h0004, 4'b0101, 0, 0);
    chk("s4_drop", drop_cnt_o, 1);
    chk("s4_model_qsize", q.size(), 2);
    chk("s4_head_pc", upd_pc_o, 32'h100);
    upd_ready_i = 1;
    step();
    chk("s4_second_pc", upd_pc_o, 32'h500);
    chk("s4_second_valid", upd_valid_o, 1);
    step();
    chk("s4_idle", upd_valid_o, 0);
    chk("s4_busy", busy_o, 0);

    // Pop and push together on a full queue.
    upd_ready_i = 0;
    ev(32'h1100, 32'h1, 1, 16'h0005, 4'b0101, 0, 0);
    ev(32'h1200, 32'h2, 0, 16'h0006, 4'b1001, 0, 0);
    step();
    chk("s5_full_valid", upd_valid_o, 1);
    chk("s5_full_head", upd_pc_o, 32'h1100);
    upd_ready_i = 1;
    ev(32'h1300, 32'h3, 1, 16'h0007, 4'b0101, 0, 0);
    chk("s5_no_drop", drop_cnt_o, 1);
    chk("s5_head_after", upd_pc_o, 32'h1200);
    step();
    chk("s5_third", upd_pc_o, 32'h1300);
    step();
    chk("s5_idle", upd_valid_o, 0);

    // Saturate the drop counter.
    upd_ready_i = 0;
    for (int i = 0; i < 262; i++)
      ev(32'h2000 + 32'(i * 4), 32'h9000, 1, 16'h0008, 4'b0101, 0, 0);
    chk("sat_drop", drop_cnt_o, 8'd255);
    chk("sat_upd_valid", upd_valid_o, 1);

    // Asynchronous reset while a write is pending.
    #2 rst = 1;
    #1;
    chk("ar_redirect_valid", redirect_valid_o, 0);
    chk("ar_redirect_pc", redirect_pc_o, 0);
    chk("ar_restore_valid", restore_valid_o, 0);
    chk("ar_restore_ckpt", restore_ckpt_o, 0);
    chk("ar_upd_valid", upd_valid_o, 0);
    chk("ar_upd_pc", upd_pc_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_drop", drop_cnt_o, 0);
    step();
    rst = 0;
    upd_ready_i = 1;
    repeat (2) step();
    chk("post_upd_valid", upd_valid_o, 0);
    chk("post_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
